// File: rtl/multiplier_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_pkg
// Shared definitions for the sequential shift-and-add multiplier and its
// arithmetic helpers: operand/product widths, FSM state encoding, sign
// constants and a 64-bit two's complement negate helper.
// -----------------------------------------------------------------------------
package multiplier_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned PROD_WIDTH = 64;
    localparam int unsigned CNT_WIDTH  = 6;

    // Counter value seen on the final iteration of a full-length run.
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = 6'd31;

    localparam logic SIGN_POSITIVE = 1'b0;
    localparam logic SIGN_NEGATIVE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Two's complement negate of a full-width product.
    function automatic logic [PROD_WIDTH-1:0] neg64(input logic [PROD_WIDTH-1:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/abs32.sv
// -----------------------------------------------------------------------------
// abs32
// Combinational magnitude of a 32-bit two's complement value, returned as an
// unsigned 32-bit number. 0x80000000 maps to unsigned 0x80000000 (no
// saturation, no overflow indication).
//
// Ports:
//   value_i  in  32  signed input value
//   mag_o    out 32  unsigned magnitude
// -----------------------------------------------------------------------------
module abs32
    import multiplier_pkg::*;
(
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] mag_o
);

    assign mag_o = value_i[WIDTH-1] ? (~value_i + 32'd1) : value_i;

endmodule

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Sequential signed 32x32 -> 64 multiplier. Operand magnitudes are multiplied
// with a radix-2 shift-and-add loop; the sign is reapplied at the end.
//
// Ports:
//   clock        in   1   sole clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   start        in   1   request, sampled only while idle
//   a            in  32   signed multiplicand
//   b            in  32   signed multiplier
//   result       out 32   low word of the signed product
//   result_high  out 32   high word of the signed product
//   busy         out  1   high from the accept edge until the final edge
//   done         out  1   one-cycle pulse, product valid
//
// Build option:
//   MULTIPLIER_EARLY_EXIT_EN  when defined, the loop stops as soon as the
//   multiplier register is empty (|b|=0 goes straight to FINISH); otherwise
//   the loop always runs 32 iterations. The product is the same either way.
// -----------------------------------------------------------------------------
module multiplier
    import multiplier_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_high,
    output logic             busy,
    output logic             done
);

    state_e                  state_q,  state_d;
    logic [PROD_WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]        mplier_q, mplier_d;
    logic [PROD_WIDTH-1:0]   acc_q,    acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q,    cnt_d;
    logic                    sign_q,   sign_d;
    logic [PROD_WIDTH-1:0]   prod_q,   prod_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;

    logic [WIDTH-1:0]        a_mag_s;
    logic [WIDTH-1:0]        b_mag_s;

    abs32 u_abs_a (
        .value_i (a),
        .mag_o   (a_mag_s)
    );

    abs32 u_abs_b (
        .value_i (b),
        .mag_o   (b_mag_s)
    );

    // Next-state and datapath updates for the IDLE/RUN/FINISH sequencer.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        prod_d   = prod_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {32'd0, a_mag_s};
                    mplier_d = b_mag_s;
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = 64'd0;
                    cnt_d    = 6'd0;
                    busy_d   = 1'b1;
`ifdef MULTIPLIER_EARLY_EXIT_EN
                    // Nothing to accumulate: skip the loop entirely.
                    if (b_mag_s == 32'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d  = RUN;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
`ifdef MULTIPLIER_EARLY_EXIT_EN
                // Leave once the shifted-out multiplier has no set bits left.
                if (mplier_q[WIDTH-1:1] == 31'd0) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
`else
                if (cnt_q == LAST_ITER) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
`endif
            end

            FINISH: begin
                if (sign_q == SIGN_NEGATIVE) begin
                    prod_d = neg64(acc_q);
                end else begin
                    prod_d = acc_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            sign_q   <= SIGN_POSITIVE;
            prod_q   <= 64'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result      = prod_q[WIDTH-1:0];
    assign result_high = prod_q[PROD_WIDTH-1:WIDTH];
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] result_high;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    multiplier dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .result      (result),
        .result_high (result_high),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Reference signed product computed with native 64-bit arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    // Edges from the accept edge to the edge that raises done.
    function automatic int exp_lat(input logic [31:0] y);
        logic [31:0] m;
        int bl;
        m  = y[31] ? (~y + 32'd1) : y;
        bl = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        return bl + 1;
`else
        return (bl >= 0) ? 33 : 0;
`endif
    endfunction

    // Drive one request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] expv);
        @(negedge clock);
        a = av; b = bv; start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for done; records latency, busy and output stability meanwhile.
    task automatic wait_done(output int cyc, output logic seen, output logic busy_ok, output logic hold_ok);
        logic [31:0] r0;
        logic [31:0] r1;
        r0 = result; r1 = result_high;
        cyc = 0; seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!seen && cyc < 100) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (result !== r0 || result_high !== r1) hold_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        int cyc; logic seen, bok, hok; logic [63:0] expv;
        reset = 1'b1; start = 1'b1; a = 32'd7; b = 32'd6;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h expected %h", result, 32'd0); end
        checks++; if (result_high !== 32'd0) begin errors++; $display("FAIL reset_result_high got %h expected %h", result_high, 32'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        // start held through release: first posedge after release must accept
        reset = 1'b0;
        exp_q.push_back(64'h0000_0000_0000_002A);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept_after_reset busy got %b expected 1", busy); end
        wait_done(cyc, seen, bok, hok);
        checks++; if (!seen) begin errors++; $display("FAIL reset_first_op_done got timeout expected done"); end
        expv = exp_q.pop_front();
        checks++; if ({result_high, result} !== expv) begin errors++; $display("FAIL reset_first_op_product got %h expected %h", {result_high, result}, expv); end
    endtask

    task automatic test_products;
        logic [31:0] ta[13];
        logic [31:0] tb[13];
        logic [63:0] te[13];
        int cyc; logic seen, bok, hok; logic [63:0] expv;
        ta[0]  = 32'd7;          tb[0]  = 32'd6;          te[0]  = 64'h0000_0000_0000_002A;
        ta[1]  = 32'hFFFF_FFFD;  tb[1]  = 32'd5;          te[1]  = 64'hFFFF_FFFF_FFFF_FFF1;
        ta[2]  = 32'h8000_0000;  tb[2]  = 32'h8000_0000;  te[2]  = 64'h4000_0000_0000_0000;
        ta[3]  = 32'd0;          tb[3]  = 32'h1234_5678;  te[3]  = 64'd0;
        ta[4]  = 32'hFFFF_FFFF;  tb[4]  = 32'hFFFF_FFFF;  te[4]  = 64'd1;
        ta[5]  = 32'h7FFF_FFFF;  tb[5]  = 32'h7FFF_FFFF;  te[5]  = 64'h3FFF_FFFF_0000_0001;
        ta[6]  = 32'h7FFF_FFFF;  tb[6]  = 32'h8000_0000;  te[6]  = 64'hC000_0000_8000_0000;
        ta[7]  = 32'd5;          tb[7]  = 32'd1;          te[7]  = 64'd5;
        ta[8]  = 32'd5;          tb[8]  = 32'd0;          te[8]  = 64'd0;
        for (int i = 9; i < 13; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; te[i] = ref_prod(ta[i], tb[i]);
        end
        for (int i = 0; i < 13; i++) begin
            issue(ta[i], tb[i], te[i]);
            wait_done(cyc, seen, bok, hok);
            checks++; if (!seen) begin errors++; $display("FAIL prod%0d_done got timeout expected done", i); end
            checks++; if (cyc !== exp_lat(tb[i])) begin errors++; $display("FAIL prod%0d_latency got %0d expected %0d", i, cyc, exp_lat(tb[i])); end
            checks++; if (!bok) begin errors++; $display("FAIL prod%0d_busy_run got drop expected continuously 1", i); end
            checks++; if (!hok) begin errors++; $display("FAIL prod%0d_hold got change expected stable during run", i); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prod%0d_busy_at_done got %b expected 0", i, busy); end
            expv = exp_q.pop_front();
            checks++; if ({result_high, result} !== expv) begin errors++; $display("FAIL prod%0d_product got %h expected %h", i, {result_high, result}, expv); end
            @(negedge clock);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL prod%0d_done_pulse got %b expected 0", i, done); end
        end
    endtask

    task automatic test_ignore_start;
        int cyc; int extra; logic seen, bok, hok; logic busy_ok; logic [63:0] expv;
        busy_ok = 1'b1;
        issue(32'd9, 32'd9, 64'd81);
        if (busy !== 1'b1) busy_ok = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        a = 32'd2; b = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        wait_done(cyc, seen, bok, hok);
        checks++; if (!seen) begin errors++; $display("FAIL ignore_done got timeout expected done"); end
        checks++; if (cyc + 5 !== exp_lat(32'd9)) begin errors++; $display("FAIL ignore_latency got %0d expected %0d", cyc + 5, exp_lat(32'd9)); end
        checks++; if (!(busy_ok && bok)) begin errors++; $display("FAIL ignore_busy got drop expected continuously 1"); end
        expv = exp_q.pop_front();
        checks++; if ({result_high, result} !== expv) begin errors++; $display("FAIL ignore_product got %h expected %h", {result_high, result}, expv); end
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_reset_abort;
        int cyc; int spurious; logic seen, bok, hok; logic [63:0] expv;
        issue(32'd100, 32'd100, 64'd10000);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        void'(exp_q.pop_front());
        checks++; if ({result_high, result} !== 64'd0) begin errors++; $display("FAIL abort_outputs got %h expected %h", {result_high, result}, 64'd0); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags got busy=%b done=%b expected busy=0 done=0", busy, done); end
        @(negedge clock);
        reset = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_no_done got %0d done pulses expected 0", spurious); end
        issue(32'd100, 32'd100, 64'd10000);
        wait_done(cyc, seen, bok, hok);
        checks++; if (!seen) begin errors++; $display("FAIL abort_restart_done got timeout expected done"); end
        expv = exp_q.pop_front();
        checks++; if ({result_high, result} !== expv) begin errors++; $display("FAIL abort_restart_product got %h expected %h", {result_high, result}, expv); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic seen, bok, hok; logic [63:0] expv;
        issue(32'd3, 32'd4, ref_prod(32'd3, 32'd4));
        wait_done(cyc, seen, bok, hok);
        checks++; if (!seen) begin errors++; $display("FAIL b2b_first_done got timeout expected done"); end
        expv = exp_q.pop_front();
        checks++; if ({result_high, result} !== expv) begin errors++; $display("FAIL b2b_first_product got %h expected %h", {result_high, result}, expv); end
        // still inside the done cycle: request the next operation
        a = 32'hFFFF_FFF8; b = 32'd11; start = 1'b1;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFA8);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b done=%b expected busy=1 done=0", busy, done); end
        wait_done(cyc, seen, bok, hok);
        checks++; if (!seen || cyc !== exp_lat(32'd11)) begin errors++; $display("FAIL b2b_second_latency got %0d expected %0d", cyc, exp_lat(32'd11)); end
        expv = exp_q.pop_front();
        checks++; if ({result_high, result} !== expv) begin errors++; $display("FAIL b2b_second_product got %h expected %h", {result_high, result}, expv); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        test_reset();
        test_products();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: start  in  1  request; sampled on posedge only while busy=0.
REQ-004 SHALL have ports: a  in  32  signed multiplicand (two's complement).
REQ-005 SHALL have ports: b  in  32  signed multiplier (two's complement).
REQ-006 SHALL have ports: result  out  32  low word of signed 64-bit product.
REQ-007 SHALL have ports: result_high  out  32  high word of signed 64-bit product.
REQ-008 SHALL have ports: busy  out  1  high from accept edge until final edge.
REQ-009 SHALL have ports: done  out  1  one-cycle pulse; product valid.

Function
REQ-010 SHALL implement states IDLE, RUN and FINISH; reset enters IDLE.
REQ-011 IDLE, start=1 at edge N: SHALL latch |a| into a 64-bit multiplicand register and |b| into a 32-bit multiplier register, set sign = a[31]^b[31], clear the 64-bit accumulator and 6-bit counter, set busy=1, and go to RUN.
REQ-012 |x| of 0x80000000 SHALL be unsigned 0x80000000; no overflow, no saturation.
REQ-013 RUN, each edge: if multiplier[0]=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-014 RUN SHALL execute k iterations on edges N+1..N+k, where k=32 (see REQ-022), then enter FINISH.
REQ-015 FINISH edge N+k+1: SHALL write {result_high,result} = sign ? -accumulator : accumulator (64-bit two's complement), clear busy, assert done for exactly one cycle, and return to IDLE.
REQ-016 start while busy=1 SHALL be ignored; it is neither queued nor allowed to alter operands.
REQ-017 a and b SHALL be ignored after the accept edge.
REQ-018 result and result_high SHALL hold their last value until the next FINISH or reset; they SHALL NOT change during RUN.
REQ-019 start=1 on the done cycle SHALL be accepted, giving back-to-back operation with no bubble.

Reset
REQ-020 reset SHALL force IDLE, result=0, result_high=0, busy=0, done=0, and clear all internal registers, including mid-RUN; the aborted operation SHALL produce no done.
REQ-021 start SHALL NOT be accepted while reset=1; the first accept is at the first posedge after deassertion.

Configuration
REQ-022 Macro MULTIPLIER_EARLY_EXIT_EN: when defined, k SHALL equal the bit-length of |b| (b=0 gives k=0, with FINISH at edge N+1), and RUN SHALL exit as soon as the multiplier register is zero; when undefined, k SHALL equal 32 regardless of operands. The product SHALL be identical in both builds.

Structure
REQ-023 State encoding and SIGN_POSITIVE/SIGN_NEGATIVE constants SHALL live in the shared defines package used by the arithmetic units.
REQ-024 A combinational sub-module abs32 (32-bit input, 32-bit magnitude output) SHALL be instantiated twice for operand magnitudes; the 64-bit final negate stays inline.

Verification
REQ-025 a=7, b=6 -> done at edge N+33 (macro off), result=0x0000002A, result_high=0.
REQ-026 a=-3, b=5 -> result=0xFFFFFFF1, result_high=0xFFFFFFFF.
REQ-027 a=b=0x80000000 -> result=0x00000000, result_high=0x40000000.
REQ-028 start at N and again at N+5 with a=9, b=9 -> single done; product 81 from the first operands; busy continuously high.
REQ-029 reset pulsed at N+10 during a=100, b=100 -> outputs 0 immediately; no done; a new start after release -> 10000.
REQ-030 Macro on, a=5, b=1 -> done at edge N+2, result=5; b=0 -> done at N+1, result=0.
